// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_e    : sequencer states (IDLE, SHIFT, DONE)
//   cnt_width  : bit-counter width for a given operand width, $clog2(width)
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // A counter of this width indexes every bit position 0..width-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// 1-bit combinational full subtractor: d = x - y - bi.
//   x  : minuend bit
//   y  : subtrahend bit
//   bi : borrow in
//   d  : difference bit
//   bo : borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   start : request, sampled only while ready
//   a, b  : minuend / subtrahend, sampled with accepted start
//   bin   : borrow in, sampled with accepted start
//   ready : idle, able to accept start
//   busy  : shifting
//   done  : one-cycle pulse, result valid
//   diff  : result, held until the next result replaces it
//   bout  : unsigned borrow out (a < b + bin)
//   ovf   : two's-complement overflow
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    // Operand sign bits are kept aside because the shift registers lose them.
    logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
    logic             bout_q, bout_d, ovf_q, ovf_d, done_q, done_d;
    logic             fs_d, fs_bo;

    full_subtractor u_fs (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .bi (br_q),
        .d  (fs_d),
        .bo (fs_bo)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        amsb_d  = amsb_q;
        bmsb_d  = bmsb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    amsb_d  = a[WIDTH-1];
                    bmsb_d  = b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = fs_bo;
                res_d = {fs_d, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    diff_d  = res_d;
                    bout_d  = fs_bo;
                    // fs_d is the result MSB on the final bit.
                    ovf_d   = (amsb_q != bmsb_q) && (fs_d != amsb_q);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            amsb_q  <= amsb_d;
            bmsb_q  <= bmsb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == SHIFT);
    assign done  = done_q;
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign ovf   = ovf_q;

endmodule
